ram_dp: RTL

- Parametrised successor to the single-port byte RAM.
- Port A: read/write with per-byte write strobes. Port B: independent read-only port.
- Read latency selectable as 1 or 2 cycles; each port reports completed reads with a one-cycle valid pulse.
- After reset, a clear sequencer writes every word to a known value before accepting accesses. Sits on the CPU/video bus as shared work RAM.

---
 rtl/ram_dp.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_dp.sv
// ram_dp: dual-port work RAM shared by the CPU and video buses.
//   Port A reads and writes, with a write strobe for each byte.
//   Port B only reads.
//   Read latency is LAT cycles (1 or 2). Each port raises a one-cycle valid
//   pulse when a read completes.
//   After reset, a clear sequencer writes CLEAR_VAL into every word. Accesses
//   are ignored until that sequence finishes.
// Optional build macro: RAM_DP_WR_FWD_EN.
//   Defined: a port B read that hits the word port A is writing in the same
//   cycle returns the merged word (new bytes where a_be=1, old bytes elsewhere).
//   Undefined: port B returns the old contents (read-before-write).
module ram_dp #(
    parameter int          A         = 10,  // address width, depth = 2**A
    parameter int          D         = 8,   // data width, multiple of 8
    parameter int          LAT       = 1,   // read latency, 1 or 2
    parameter logic [D-1:0] CLEAR_VAL = '0
) (
    input  logic           clk,
    input  logic           reset,
    output logic           busy,
    input  logic           a_cs,
    input  logic           a_rw,
    input  logic [D/8-1:0] a_be,
    input  logic [A-1:0]   a_addr,
    input  logic [D-1:0]   a_data_in,
    output logic [D-1:0]   a_data_out,
    output logic           a_valid,
    input  logic           b_cs,
    input  logic [A-1:0]   b_addr,
    output logic [D-1:0]   b_data_out,
    output logic           b_valid
);

    localparam int NB    = D / 8;
    localparam int DEPTH = 2 ** A;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t         state_reg, state_next;
    logic [A-1:0]   cnt_reg, cnt_next;

    logic           run;
    logic           a_rd, b_rd;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [D-1:0]   wr_data;
    logic [NB-1:0]  wr_be;
    logic [NB-1:0]  fwd_be;

    logic [D-1:0]   a_s1, b_s1;
    logic           a_v1_reg, b_v1_reg;

    // State and clear-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: the counter walks every address once, then the FSM enters RUN
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                cnt_next = cnt_reg + A'(1);
                if (cnt_reg == {A{1'b1}}) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign run  = (state_reg == RUN) && !reset;
    assign busy = (state_reg == CLEAR);
    assign a_rd = run && a_cs && a_rw;
    assign b_rd = run && b_cs;

    // Single write port: the clear sequencer owns it while busy, port A otherwise
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = a_addr;
        wr_data = a_data_in;
        wr_be   = a_be;
        if (!reset) begin
            if (state_reg == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = cnt_reg;
                wr_data = CLEAR_VAL;
                wr_be   = '1;
            end else if (a_cs && !a_rw) begin
                wr_en   = 1'b1;
            end
        end
    end

`ifdef RAM_DP_WR_FWD_EN
    // Lanes of a same-address port A write that port B must see immediately
    assign fwd_be = (run && a_cs && !a_rw && b_cs && (a_addr == b_addr)) ? a_be : '0;
`else
    assign fwd_be = '0;
`endif

    // One 8-bit memory array per byte lane, so that each byte strobe is a
    // plain lane write enable
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] a_q_reg;
            logic [7:0] b_q_reg;

            // Lane write
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    mem[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            // Port A registered read; holds until the next accepted read
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q_reg <= '0;
                end else if (a_rd) begin
                    a_q_reg <= mem[a_addr];
                end
            end

            // Port B registered read, with optional same-cycle forwarding
            always_ff @(posedge clk) begin
                if (reset) begin
                    b_q_reg <= '0;
                end else if (b_rd) begin
                    if (fwd_be[gi]) begin
                        b_q_reg <= a_data_in[8*gi +: 8];
                    end else begin
                        b_q_reg <= mem[b_addr];
                    end
                end
            end

            assign a_s1[8*gi +: 8] = a_q_reg;
            assign b_s1[8*gi +: 8] = b_q_reg;
        end
    endgenerate

    // First-stage valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            a_v1_reg <= 1'b0;
            b_v1_reg <= 1'b0;
        end else begin
            a_v1_reg <= a_rd;
            b_v1_reg <= b_rd;
        end
    end

    generate
        if (LAT == 2) begin : g_lat2
            logic [D-1:0] a_q2_reg, b_q2_reg;
            logic         a_v2_reg, b_v2_reg;

            // Second pipeline stage: data moves only with its valid, so it holds otherwise
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q2_reg <= '0;
                    b_q2_reg <= '0;
                    a_v2_reg <= 1'b0;
                    b_v2_reg <= 1'b0;
                end else begin
                    a_v2_reg <= a_v1_reg;
                    b_v2_reg <= b_v1_reg;
                    if (a_v1_reg) begin
                        a_q2_reg <= a_s1;
                    end
                    if (b_v1_reg) begin
                        b_q2_reg <= b_s1;
                    end
                end
            end

            assign a_data_out = a_q2_reg;
            assign b_data_out = b_q2_reg;
            assign a_valid    = a_v2_reg;
            assign b_valid    = b_v2_reg;
        end else begin : g_lat1
            assign a_data_out = a_s1;
            assign b_data_out = b_s1;
            assign a_valid    = a_v1_reg;
            assign b_valid    = b_v1_reg;
        end
    endgenerate

endmodule
